// File: rtl/click_rr_arb.sv
// Round-robin arbiter that funnels N_REQ two-phase requesters into one
// bundled-data click stage input, one item in flight at a time.
module click_rr_arb #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ack,
    output logic [DATA_W-1:0]         buf_data,
    output logic                      buf_req,
    input  logic                      buf_ack,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      err
);

    localparam int         ID_W   = $clog2(N_REQ);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [N_REQ-1:0]    req_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [N_REQ-1:0]    req_s;
    logic                ack_s;
    logic [N_REQ-1:0]    pending;

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     sel;
    logic                sel_vld;
    int                  idx;

    logic [7:0]          wait_cnt;
    logic                latch_en;
    logic                toggle_en;
    logic                done;
    logic                cnt_en;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF)
            return v;
        return v + 8'd1;
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (id == ID_W'(N_REQ - 1))
            return '0;
        return id + 1'b1;
    endfunction

    // Synchronizer stage: requests and the click-stage ack enter the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                req_sync[s] <= '0;
            ack_sync <= '0;
        end else begin
            req_sync[0] <= req_req;
            for (int s = 1; s < SYNC_STAGES; s++)
                req_sync[s] <= req_sync[s-1];
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], buf_ack};
        end
    end

    assign req_s   = req_sync[SYNC_STAGES-1];
    assign ack_s   = ack_sync[SYNC_STAGES-1];
    assign pending = req_s ^ req_ack;

    // Arbitration: the lowest offset from rr_ptr wins, so scan offsets downward
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (pending[idx]) begin
                sel     = ID_W'(idx);
                sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        toggle_en  = 1'b0;
        done       = 1'b0;
        cnt_en     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    latch_en   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                toggle_en  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (ack_s == buf_req) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output stage: data is latched a full cycle before buf_req toggles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ack  <= '0;
            buf_data <= '0;
            buf_req  <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (latch_en) begin
                buf_data <= req_data[sel*DATA_W +: DATA_W];
                grant_id <= sel;
            end
            if (toggle_en) begin
                buf_req  <= ~buf_req;
                wait_cnt <= '0;
            end
            if (done) begin
                req_ack[grant_id] <= ~req_ack[grant_id];
                rr_ptr            <= next_ptr(grant_id);
            end
            if (cnt_en) begin
                wait_cnt <= sat_inc(wait_cnt);
                if (sat_inc(wait_cnt) >= TO_LIM)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_click_rr_arb.sv
// Directed bench for click_rr_arb: vector table for arbitration order plus
// hand-written sequences for timeout, reset mid-WAIT and streaming.
module tb_click_rr_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_req;
    logic [7:0]  req_data;
    logic [3:0]  req_ack;
    logic [1:0]  buf_data;
    logic        buf_req;
    logic        buf_ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic       auto_ack = 1'b1;
    logic       last_req = 1'b0;
    logic [1:0] prev_data = 2'b00;
    logic [1:0] sb_id[$];
    logic [1:0] sb_data[$];

    typedef struct {
        logic [3:0] tog;
        logic [7:0] data;
        int         n;
        logic [5:0] ids;
        logic [5:0] dats;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    click_rr_arb #(
        .N_REQ(4), .DATA_W(2), .SYNC_STAGES(2), .TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset), .req_req(req_req), .req_data(req_data),
        .req_ack(req_ack), .buf_data(buf_data), .buf_req(buf_req),
        .buf_ack(buf_ack), .grant_id(grant_id), .busy(busy), .err(err)
    );

    // Click-stage model and scoreboard of every buf_req toggle
    always @(negedge clk) begin
        if (reset) begin
            buf_ack  = 1'b0;
            last_req = 1'b0;
        end else begin
            if (buf_req !== last_req) begin
                tests++;
                if (buf_data !== prev_data) begin
                    fails++;
                    $display("FAIL setup: buf_data=%b at req toggle, previous cycle %b",
                             buf_data, prev_data);
                end
                sb_id.push_back(grant_id);
                sb_data.push_back(buf_data);
                last_req = buf_req;
            end
            if (auto_ack)
                buf_ack = buf_req;
        end
        prev_data = buf_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input logic [3:0] exp, input int limit);
        bit ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (req_ack === exp && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: timed out, req_ack=%b busy=%b, expected req_ack=%b",
                     name, req_ack, busy, exp);
        end
    endtask

    task automatic wait_grants(input string name, input int n, input int limit);
        bit ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (sb_id.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: timed out, %0d buf_req toggles, expected %0d",
                     name, sb_id.size(), n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ack"},  32'(req_ack),  32'd0);
        check({tag, " buf_req"},  32'(buf_req),  32'd0);
        check({tag, " buf_data"}, 32'(buf_data), 32'd0);
        check({tag, " grant_id"}, 32'(grant_id), 32'd0);
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " err"},      32'(err),      32'd0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{tog: 4'b1011, data: 8'b11_00_10_01, n: 3,
                    ids: {2'd3, 2'd1, 2'd0}, dats: {2'b11, 2'b10, 2'b01}};
        vecs[1] = '{tog: 4'b1001, data: 8'b00_00_00_11, n: 2,
                    ids: {2'd0, 2'd3, 2'd0}, dats: {2'b00, 2'b00, 2'b11}};
        vecs[2] = '{tog: 4'b0100, data: 8'b00_10_00_00, n: 1,
                    ids: {2'd0, 2'd0, 2'd2}, dats: {2'b00, 2'b00, 2'b10}};
        vecs[3] = '{tog: 4'b1001, data: 8'b01_00_00_10, n: 2,
                    ids: {2'd0, 2'd0, 2'd3}, dats: {2'b00, 2'b10, 2'b01}};
        vecs[4] = '{tog: 4'b0111, data: 8'b00_11_01_00, n: 3,
                    ids: {2'd0, 2'd2, 2'd1}, dats: {2'b00, 2'b11, 2'b01}};
        vecs[5] = '{tog: 4'b1100, data: 8'b10_01_00_00, n: 2,
                    ids: {2'd0, 2'd3, 2'd2}, dats: {2'b00, 2'b10, 2'b01}};

        req_req  = 4'b0000;
        req_data = 8'h00;
        buf_ack  = 1'b0;
        wait_cycles(3);
        check_all_zero("reset");
        reset = 1'b0;
        wait_cycles(3);
        check_all_zero("post-reset idle");

        for (int v = 0; v < 6; v++) begin
            sb_id.delete();
            sb_data.delete();
            @(negedge clk);
            req_data = vecs[v].data;
            req_req  = req_req ^ vecs[v].tog;
            wait_idle($sformatf("vec%0d done", v), req_req, 300);
            wait_cycles(6);
            check($sformatf("vec%0d grant count", v), 32'(sb_id.size()), 32'(vecs[v].n));
            for (int j = 0; j < vecs[v].n; j++) begin
                if (j < sb_id.size()) begin
                    check($sformatf("vec%0d grant%0d id", v, j),
                          32'(sb_id[j]), 32'(vecs[v].ids[j*2 +: 2]));
                    check($sformatf("vec%0d grant%0d data", v, j),
                          32'(sb_data[j]), 32'(vecs[v].dats[j*2 +: 2]));
                end
            end
            check($sformatf("vec%0d req_ack", v), 32'(req_ack), 32'(req_req));
            check($sformatf("vec%0d grant_id", v), 32'(grant_id),
                  32'(vecs[v].ids[(vecs[v].n-1)*2 +: 2]));
            check($sformatf("vec%0d busy", v), 32'(busy), 32'd0);
        end

        // Timeout: click stage never answers until released by hand
        sb_id.delete();
        sb_data.delete();
        auto_ack = 1'b0;
        @(negedge clk);
        req_data   = 8'b00_00_11_00;
        req_req[1] = ~req_req[1];
        wait_grants("timeout grant", 1, 50);
        wait_cycles(100);
        check("timeout err early", 32'(err), 32'd0);
        check("timeout busy early", 32'(busy), 32'd1);
        wait_cycles(200);
        check("timeout err set", 32'(err), 32'd1);
        check("timeout still waiting", 32'(busy), 32'd1);
        @(negedge clk);
        buf_ack  = buf_req;
        auto_ack = 1'b1;
        wait_idle("timeout ack delivered", req_req, 50);
        check("timeout grant_id", 32'(grant_id), 32'd1);
        wait_cycles(5);
        check("timeout err sticky", 32'(err), 32'd1);
        @(negedge clk);
        reset   = 1'b1;
        req_req = 4'b0000;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(2);
        check("err cleared by reset", 32'(err), 32'd0);

        // Reset asserted while an item is in flight
        sb_id.delete();
        sb_data.delete();
        auto_ack = 1'b0;
        @(negedge clk);
        req_data   = 8'b11_00_00_00;
        req_req[3] = 1'b1;
        wait_grants("midwait grant", 1, 50);
        wait_cycles(3);
        check("midwait busy", 32'(busy), 32'd1);
        check("midwait buf_req", 32'(buf_req), 32'd1);
        #2;
        reset   = 1'b1;
        req_req = 4'b0000;
        #1;
        check_all_zero("async reset");
        wait_cycles(2);
        reset    = 1'b0;
        auto_ack = 1'b1;
        sb_id.delete();
        sb_data.delete();
        @(negedge clk);
        req_data   = 8'b00_00_01_00;
        req_req[1] = 1'b1;
        wait_idle("after reset served", 4'b0010, 60);
        check("after reset count", 32'(sb_id.size()), 32'd1);
        if (sb_id.size() > 0) begin
            check("after reset id", 32'(sb_id[0]), 32'd1);
            check("after reset data", 32'(sb_data[0]), 32'b01);
        end
        check("after reset grant_id", 32'(grant_id), 32'd1);

        // Streaming from requester 0
        sb_id.delete();
        sb_data.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_data[1:0] = 2'(i % 4);
            req_req[0]    = ~req_req[0];
            wait_idle($sformatf("stream item%0d", i), req_req, 60);
        end
        wait_cycles(6);
        check("stream count", 32'(sb_id.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < sb_id.size()) begin
                check($sformatf("stream%0d id", i), 32'(sb_id[i]), 32'd0);
                check($sformatf("stream%0d data", i), 32'(sb_data[i]), 32'(i % 4));
            end
        end
        check("stream err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
